// File: rtl/merge_pkg.sv
// -----------------------------------------------------------------------------
// merge_pkg
// Shared definitions for the merge_packer stage of the frame merger:
//   - beat type codes carried on o_type
//   - packer FSM state encoding
//   - lane / output word width helpers
// -----------------------------------------------------------------------------
package merge_pkg;

  // Beat type codes seen by the bus/DMA side.
  localparam logic [1:0] TYPE_HDR = 2'b00;
  localparam logic [1:0] TYPE_DAT = 2'b01;
  localparam logic [1:0] TYPE_TRL = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    DATA    = 2'd2,
    TRAILER = 2'd3
  } state_t;

  // One lane holds {th, data}.
  function automatic int lane_width(input int dw, input int thw);
    return dw + thw;
  endfunction

  // One output data word holds PACK lanes side by side.
  function automatic int word_width(input int pack, input int ew);
    return pack * ew;
  endfunction

endpackage

// File: rtl/merge_packer.sv
// -----------------------------------------------------------------------------
// merge_packer
// Packs the sorted triple stream of the frame merger into wide output words.
// Every merged group (entries up to and including i_last) leaves as:
//   header  : o_type=00, o_data = {0, sh, thh}   (thh in the LSBs)
//   data    : o_type=01, up to PACK lanes, lane 0 in the LSBs, o_keep = lanes
//   trailer : o_type=10, o_data = {0, entry count}, o_last=1
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   i_valid/i_ready     upstream handshake (i_ready only in DATA)
//   i_last              final entry of a merged group
//   i_data, i_th        entry payload; lane = {i_th, i_data}
//   i_sh, i_thh         group side fields, sampled when the header loads
//   o_valid/o_ready     downstream handshake
//   o_last              marks the trailer beat
//   o_type              beat type (TYPE_HDR / TYPE_DAT / TYPE_TRL)
//   o_keep              lane-valid mask on data beats, 0 otherwise
//   o_data              beat payload
// -----------------------------------------------------------------------------
module merge_packer
  import merge_pkg::*;
#(
  parameter int DW   = 8,
  parameter int THW  = 2,
  parameter int SHW  = 32,
  parameter int THHW = 32,
  parameter int PACK = 8,
  parameter int CW   = 16
) (
  input  logic                                        clk,
  input  logic                                        reset,
  output logic                                        i_ready,
  input  logic                                        i_valid,
  input  logic                                        i_last,
  input  logic [DW-1:0]                               i_data,
  input  logic [THW-1:0]                              i_th,
  input  logic [SHW-1:0]                              i_sh,
  input  logic [THHW-1:0]                             i_thh,
  input  logic                                        o_ready,
  output logic                                        o_valid,
  output logic                                        o_last,
  output logic [1:0]                                  o_type,
  output logic [PACK-1:0]                             o_keep,
  output logic [word_width(PACK, lane_width(DW, THW))-1:0] o_data
);

  localparam int EW  = lane_width(DW, THW);
  localparam int OW  = word_width(PACK, EW);
  localparam int LCW = (PACK > 1) ? $clog2(PACK) : 1;

  // Header and trailer payloads must fit in one output word.
  if (OW < SHW + THHW || OW < CW) begin : g_width_check
    $error("merge_packer: OW=%0d too narrow for SHW+THHW=%0d or CW=%0d",
           OW, SHW + THHW, CW);
  end

  state_t         state;
  logic [LCW-1:0] lane_cnt;
  logic [CW-1:0]  count;
  logic [OW-1:0]  acc;

  logic           out_free;
  logic           in_fire;
  logic           word_done;
  logic [EW-1:0]  entry;
  logic [OW-1:0]  word_next;
  logic [PACK-1:0] keep_next;
  logic [CW-1:0]  count_next;

  // The output register may load when it is empty or being drained this cycle.
  assign out_free = !o_valid || o_ready;

  // i_ready depends only on state and the output side, never on i_valid/i_last.
  assign i_ready  = (state == DATA) && out_free;
  assign in_fire  = i_valid && i_ready;
  assign entry    = {i_th, i_data};

  // A word closes on its last lane or at the end of the group.
  assign word_done = (lane_cnt == LCW'(PACK - 1)) || i_last;

  // Entry counter saturates instead of wrapping.
  assign count_next = (&count) ? count : count + CW'(1);

  // Accumulator with the incoming entry dropped into the current lane, plus
  // the LSB-contiguous mask of lanes filled once it is in.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    word_next = acc;
    keep_next = '0;
    for (int k = 0; k < PACK; k++) begin
      if (LCW'(k) == lane_cnt) begin
        word_next[k*EW +: EW] = entry;
      end
      keep_next[k] = (LCW'(k) <= lane_cnt);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read
  // in this block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the accumulator is a plain register, not a memory, so it is
      // reset with everything else; a new group never sees stale lanes.
      state    <= IDLE;
      lane_cnt <= '0;
      count    <= '0;
      acc      <= '0;
      o_valid  <= 1'b0;
      o_last   <= 1'b0;
      o_type   <= TYPE_HDR;
      o_keep   <= '0;
      o_data   <= '0;
    end else begin
      // A beat accepted without a replacement leaves the register empty;
      // any load below re-asserts o_valid in the same cycle.
      if (out_free) begin
        o_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (i_valid) begin
            state <= HEADER;
          end
        end

        HEADER: begin
          if (out_free) begin
            o_valid <= 1'b1;
            o_type  <= TYPE_HDR;
            o_data  <= OW'({i_sh, i_thh});
            o_keep  <= '0;
            o_last  <= 1'b0;
            state   <= DATA;
          end
        end

        DATA: begin
          if (in_fire) begin
            count <= count_next;
            if (word_done) begin
              // in_fire implies out_free, so the output register is ours.
              o_valid  <= 1'b1;
              o_type   <= TYPE_DAT;
              o_data   <= word_next;
              o_keep   <= keep_next;
              o_last   <= 1'b0;
              acc      <= '0;
              lane_cnt <= '0;
            end else begin
              acc      <= word_next;
              lane_cnt <= lane_cnt + LCW'(1);
            end
            if (i_last) begin
              state <= TRAILER;
            end
          end
        end

        TRAILER: begin
          if (out_free) begin
            o_valid <= 1'b1;
            o_type  <= TYPE_TRL;
            o_data  <= OW'(count);
            o_keep  <= '0;
            o_last  <= 1'b1;
            count   <= '0;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_merge_packer.sv
// -----------------------------------------------------------------------------
// tb_merge_packer
// Randomised and directed stimulus for merge_packer. The expected beat stream
// of each group is built from the framing rules (header, ceil(N/PACK) data
// words, trailer) and compared beat by beat whenever a beat is transferred.
// -----------------------------------------------------------------------------
module tb_merge_packer;
  import merge_pkg::*;

  localparam int DW   = 8;
  localparam int THW  = 2;
  localparam int SHW  = 32;
  localparam int THHW = 32;
  localparam int PACK = 8;
  localparam int CW   = 16;
  localparam int EW   = DW + THW;
  localparam int OW   = PACK * EW;

  typedef struct {
    logic [1:0]      t;
    logic [OW-1:0]   d;
    logic [PACK-1:0] k;
    logic            l;
    int              c;
  } beat_t;

  logic            clk;
  logic            reset;
  logic            i_ready;
  logic            i_valid;
  logic            i_last;
  logic [DW-1:0]   i_data;
  logic [THW-1:0]  i_th;
  logic [SHW-1:0]  i_sh;
  logic [THHW-1:0] i_thh;
  logic            o_ready;
  logic            o_valid;
  logic            o_last;
  logic [1:0]      o_type;
  logic [PACK-1:0] o_keep;
  logic [OW-1:0]   o_data;

  merge_packer #(
    .DW(DW), .THW(THW), .SHW(SHW), .THHW(THHW), .PACK(PACK), .CW(CW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_ready (i_ready),
    .i_valid (i_valid),
    .i_last  (i_last),
    .i_data  (i_data),
    .i_th    (i_th),
    .i_sh    (i_sh),
    .i_thh   (i_thh),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_last  (o_last),
    .o_type  (o_type),
    .o_keep  (o_keep),
    .o_data  (o_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  beat_t      exp_q[$];
  beat_t      obs_q[$];
  logic [EW-1:0] ents[$];
  int         rdy_mode  = 0;   // 0: always ready, 1: random, 2: held low
  int         start_cyc = 0;
  int         first_hs  = 0;
  int         last_hs   = 0;

  // ---------------------------------------------------------------- model
  // Expected beats for the group held in ents[].
  function automatic void push_model(input logic [SHW-1:0] sh,
                                     input logic [THHW-1:0] thh);
    int    n = ents.size();
    beat_t b;
    b.t = TYPE_HDR; b.d = '0; b.d[SHW+THHW-1:0] = {sh, thh};
    b.k = '0; b.l = 1'b0; b.c = 0;
    exp_q.push_back(b);
    for (int s = 0; s < n; s += PACK) begin
      int m = (n - s < PACK) ? (n - s) : PACK;
      b.t = TYPE_DAT; b.d = '0; b.k = '0; b.l = 1'b0;
      for (int j = 0; j < m; j++) begin
        b.d[j*EW +: EW] = ents[s+j];
        b.k[j] = 1'b1;
      end
      exp_q.push_back(b);
    end
    b.t = TYPE_TRL; b.d = '0;
    b.d[CW-1:0] = (n > (1 << CW) - 1) ? CW'((1 << CW) - 1) : CW'(n);
    b.k = '0; b.l = 1'b1;
    exp_q.push_back(b);
  endfunction

  function automatic beat_t obs_at(input int i);
    beat_t z;
    z.t = '1; z.d = '1; z.k = '1; z.l = 1'bx; z.c = -1000;
    if (i < obs_q.size()) return obs_q[i];
    return z;
  endfunction

  // ---------------------------------------------------------------- o_ready
  initial begin
    o_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       o_ready = 1'b1;
        1:       o_ready = ($urandom_range(0, 9) < 7);
        default: o_ready = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------- monitor
  logic [127:0] saved;
  logic         stalled = 1'b0;
  beat_t        act_b, exp_b;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        stalled = 1'b0;
      end else begin
        if (stalled)
          check("hold_while_stalled", {o_valid, o_type, o_keep, o_last, o_data}, saved);
        if (o_valid && !o_ready)
          check("i_ready_low_when_stalled", i_ready, 1'b0);
        if (o_valid && o_ready) begin
          act_b.t = o_type; act_b.d = o_data; act_b.k = o_keep;
          act_b.l = o_last; act_b.c = cyc;
          if (exp_q.size() == 0) begin
            check("unexpected_beat", {o_type, o_keep, o_last, o_data}, 128'h0);
          end else begin
            exp_b = exp_q.pop_front();
            check("beat", {act_b.t, act_b.k, act_b.l, act_b.d},
                          {exp_b.t, exp_b.k, exp_b.l, exp_b.d});
          end
          obs_q.push_back(act_b);
        end
        stalled = o_valid && !o_ready;
        saved   = {o_valid, o_type, o_keep, o_last, o_data};
      end
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic fill_random(input int n);
    ents.delete();
    for (int i = 0; i < n; i++)
      ents.push_back({THW'($urandom_range(0, 3)), DW'($urandom)});
  endtask

  // Called aligned just after a rising edge. Sends ents[0..stop-1].
  task automatic send_group(input logic [SHW-1:0] sh, input logic [THHW-1:0] thh,
                            input int stop, input bit gaps);
    int n     = ents.size();
    int idx   = 0;
    int guard = 0;
    logic hs;
    push_model(sh, thh);
    i_sh = sh;
    i_thh = thh;
    start_cyc = cyc;
    first_hs = -1;
    while (idx < n && idx < stop) begin
      i_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      i_data  = ents[idx][DW-1:0];
      i_th    = ents[idx][EW-1:DW];
      i_last  = (idx == n - 1);      // also presented during gaps, must be ignored
      @(negedge clk);
      hs = i_valid && i_ready;
      if (hs) begin
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        idx++;
      end
      @(posedge clk);
      #1;
      guard++;
      if (guard > 2000) begin
        check("input_timeout", idx, n);
        break;
      end
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- tests
  beat_t b;

  initial begin
    reset = 1'b1; i_valid = 1'b0; i_last = 1'b0; i_data = '0; i_th = '0;
    i_sh = '0; i_thh = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {o_valid, o_last, o_type, o_keep, o_data, i_ready}, 128'h0);
    reset = 1'b0;

    // Group of 3 with known contents; also pins header latency.
    ents.delete();
    ents.push_back(10'h111); ents.push_back(10'h122); ents.push_back(10'h133);
    obs_q.delete();
    send_group(32'hA5A5A5A5, 32'h12345678, 1000, 1'b0);
    wait_drain();
    check("g3_beats", obs_q.size(), 3);
    b = obs_at(0);
    check("g3_hdr", {b.t, b.k, b.l, b.d}, {TYPE_HDR, 8'h00, 1'b0, 80'hA5A5A5A5_12345678});
    check("g3_hdr_latency", b.c - start_cyc, 2);
    b = obs_at(1);
    check("g3_lane0", b.d[EW-1:0], 10'h111);
    check("g3_data", {b.t, b.k, b.d}, {TYPE_DAT, 8'h07, 80'h13348911});
    b = obs_at(2);
    check("g3_trl", {b.t, b.k, b.l, b.d}, {TYPE_TRL, 8'h00, 1'b1, 80'd3});

    // Exactly PACK entries: no empty data beat.
    fill_random(8);
    obs_q.delete();
    send_group($urandom, $urandom, 1000, 1'b0);
    wait_drain();
    check("g8_beats", obs_q.size(), 3);
    b = obs_at(1);
    check("g8_keep", b.k, 8'hFF);
    b = obs_at(2);
    check("g8_count", b.d, 80'd8);

    // 17 entries at full rate.
    fill_random(17);
    obs_q.delete();
    send_group($urandom, $urandom, 1000, 1'b0);
    wait_drain();
    check("g17_beats", obs_q.size(), 5);
    check("g17_keeps", {obs_at(1).k, obs_at(2).k, obs_at(3).k}, 24'hFFFF01);
    check("g17_count", obs_at(4).d, 80'd17);
    check("g17_rate", last_hs - first_hs, 16);

    // Downstream stall of 5 cycles mid-group.
    fill_random(20);
    obs_q.delete();
    fork
      send_group($urandom, $urandom, 1000, 1'b0);
      begin
        repeat (6) @(posedge clk);
        #1 rdy_mode = 2;
        repeat (5) @(posedge clk);
        #1 rdy_mode = 0;
      end
    join
    wait_drain();
    check("stall_beats", obs_q.size(), 5);
    check("stall_count", obs_at(4).d, 80'd20);

    // Reset after 4 of 10 entries.
    fill_random(10);
    send_group($urandom, $urandom, 4, 1'b0);
    reset = 1'b1;
    #1;
    check("midreset_outputs", {o_valid, o_last, o_type, o_keep, o_data, i_ready}, 128'h0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    fill_random(5);
    obs_q.delete();
    send_group($urandom, $urandom, 1000, 1'b0);
    wait_drain();
    check("post_reset_hdr_type", obs_at(0).t, TYPE_HDR);
    check("post_reset_keep", obs_at(1).k, 8'h1F);
    check("post_reset_count", obs_at(2).d, 80'd5);

    // Back-to-back groups of 2 then 9.
    obs_q.delete();
    fill_random(2);
    send_group(32'h11112222, 32'h33334444, 1000, 1'b0);
    fill_random(9);
    send_group(32'hCAFEF00D, 32'h0BADBEEF, 1000, 1'b0);
    wait_drain();
    check("b2b_beats", obs_q.size(), 7);
    check("b2b_count1", obs_at(2).d, 80'd2);
    check("b2b_hdr2", obs_at(3).d, 80'hCAFEF00D_0BADBEEF);
    check("b2b_gap", obs_at(3).c - obs_at(2).c, 2);
    check("b2b_count2", obs_at(6).d, 80'd9);

    // Random groups, random backpressure and input gaps.
    rdy_mode = 1;
    for (int g = 0; g < 25; g++) begin
      fill_random($urandom_range(1, 20));
      send_group($urandom, $urandom, 1000, bit'($urandom_range(0, 1)));
    end
    wait_drain();
    rdy_mode = 0;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
